// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Operands are registered onto the ALU inputs on accept, the result is
// captured one cycle later and returned with the requester ID over a
// valid/ready response channel.
// Build option: define ALU_ARBITER_RR_EN for round-robin tie-break;
// otherwise requester 0 always wins a tie.
module alu_arbiter #(
  parameter int W    = 8,
  parameter int SELW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic            req1_valid,
  output logic            req0_ready,
  output logic            req1_ready,
  input  logic [W-1:0]    req0_a,
  input  logic [W-1:0]    req0_b,
  input  logic [W-1:0]    req1_a,
  input  logic [W-1:0]    req1_b,
  input  logic            req0_cin,
  input  logic            req1_cin,
  input  logic [SELW-1:0] req0_sel,
  input  logic [SELW-1:0] req1_sel,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic            alu_cin,
  output logic [SELW-1:0] alu_sel,
  input  logic [W-1:0]    alu_y,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_y,
  output logic            rsp_id,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t state, state_nx;
  logic   grant0, grant1;
  logic   accept;

`ifdef ALU_ARBITER_RR_EN
  // Last-served requester; resets to 1 so requester 0 wins the first tie.
  logic last;

  // Pointer update: remember who was served on every accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last <= 1'b1;
    else if (accept) last <= grant1;
  end

  // Round-robin arbitration, only offered in IDLE.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      grant0 = req0_valid && (!req1_valid || last);
      grant1 = req1_valid && (!req0_valid || !last);
    end
  end
`else
  // Fixed-priority arbitration, only offered in IDLE.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      grant0 = req0_valid;
      grant1 = req1_valid && !req0_valid;
    end
  end
`endif

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 || grant1;
  assign busy       = (state == EXEC) || (state == RESP);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; unused encoding falls back to IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operands/ID latched on accept, result captured leaving EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cin   <= 1'b0;
      alu_sel   <= '0;
      rsp_y     <= '0;
      rsp_id    <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      if (accept) begin
        alu_a   <= grant1 ? req1_a   : req0_a;
        alu_b   <= grant1 ? req1_b   : req0_b;
        alu_cin <= grant1 ? req1_cin : req0_cin;
        alu_sel <= grant1 ? req1_sel : req0_sel;
        rsp_id  <= grant1;
      end
      if (state == EXEC) rsp_y <= alu_y;
      // Valid tracks residency in RESP, so it drops on the handshake edge.
      rsp_valid <= (state_nx == RESP);
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the MiniCPU 8-bit combinational ALU between two requesters. The block accepts one operation at a time over a valid/ready handshake, registers the operands onto the ALU inputs, and captures the ALU result one cycle later. It then returns the result with the requester ID over a valid/ready response channel. The block sits between the ALU and its clients, for example the execute stage and a debug/microcode port; it is opcode-agnostic and passes `sel` through unchanged.

## Interface
- `W`, 8, operand/result width.
- `SELW`, 4, ALU operation-select width.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req0_valid`, `req1_valid`  in  1 each  request valid, per requester.
- `req0_ready`, `req1_ready`  out  1 each  request accepted this cycle.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  W each  operands.
- `req0_cin`, `req1_cin`  in  1 each  carry-in.
- `req0_sel`, `req1_sel`  in  SELW each  ALU operation select.
- `alu_a`, `alu_b`  out  W each  registered ALU operands.
- `alu_cin`  out  1  registered ALU carry-in.
- `alu_sel`  out  SELW  registered ALU select.
- `alu_y`  in  W  combinational ALU result.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_y`  out  W  captured result.
- `rsp_id`  out  1  requester that issued the op (0/1).
- `busy`  out  1  high in EXEC or RESP.

## Operation
- FSM states:
  - **IDLE**: arbitrate.
  - **EXEC**: ALU evaluates registered operands.
  - **RESP**: hold result until consumed.
- IDLE arbitration (combinational):
  - only one `reqN_valid` high → that requester is granted;
  - both high → round-robin, the requester not served last wins;
  - grant asserts `reqN_ready` only in IDLE and only for the granted requester; at most one ready is high.
- Accept (IDLE, granted valid&ready at edge):
  - latch a/b/cin/sel into `alu_*`;
  - latch the ID;
  - set last-served pointer = ID;
  - go to EXEC.
- EXEC: at the next edge, capture `alu_y` into `rsp_y`, set `rsp_valid`=1, go to RESP.
- RESP:
  - `rsp_valid`, `rsp_y`, `rsp_id` are held stable until `rsp_valid&rsp_ready`;
  - on that edge: `rsp_valid`=0, go to IDLE.
  - No new request is accepted in the same cycle.
- `alu_*` change only on accept; they hold their last values otherwise.
- Requests arriving outside IDLE see ready=0. The requester must hold its request stable until ready (standard valid/ready).
- Widths: pure pass-through, no arithmetic in this block; `rsp_y` is exactly `alu_y` sampled at the end of EXEC.
- Unused codes: none; FSM encoding 2 bits, illegal state → IDLE.

## Timing
- Reset (async assert, sync-safe deassert via the flop reset):
  - state=IDLE;
  - `alu_a`=`alu_b`=0, `alu_cin`=0, `alu_sel`=0;
  - `rsp_valid`=0, `rsp_y`=0, `rsp_id`=0, `busy`=0;
  - last-served=1, so requester 0 wins the first tie.
- Accept at edge N → `alu_*` valid after N → `rsp_valid`=1 after edge N+1 (result visible in cycle N+2 when `rsp_ready` is held high).
- Minimum issue interval: 3 cycles (IDLE, EXEC, RESP) with `rsp_ready` held high.
- `busy`=1 from edge N through the response handshake edge.
- Reset mid-operation (EXEC or RESP):
  - the in-flight op is dropped, no response;
  - the pointer returns to its reset value.
- Simultaneous new request and response handshake in RESP: the request waits one cycle and is arbitrated in IDLE.

## Configuration
- `ALU_ARBITER_RR_EN`:
  - defined → round-robin tie-break as above;
  - undefined → fixed priority, requester 0 always wins a tie; the last-served pointer is not implemented.

## Test plan
- Single op, behavioural ALU with sel=7 as add-with-carry: req0 a=8'h93, b=8'hA7, cin=1, sel=7 → `alu_*` driven one cycle after accept; `rsp_valid` with `rsp_y`=8'h3B, `rsp_id`=0.
- Tie, RR enabled: both valid continuously, each issuing 4 ops → ids alternate 0,1,0,1,0,1,0,1 starting with 0; never both readies high.
- Tie, `ALU_ARBITER_RR_EN` undefined: both valid → all of req0's ops served before any of req1's.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP → `rsp_y`/`rsp_id` stable, `req*_ready`=0, `busy`=1; release → IDLE next cycle.
- Reset in EXEC: assert `rst_n`=0 mid-cycle → all outputs reach reset values immediately; no `rsp_valid` after deassert; next tie is won by requester 0.
- Operand hold: after a response, change `req0_a` with valid=0 → `alu_a` unchanged until the next accept.
